// File: rtl/fazyrv_arb_pkg.sv
// Shared types and constants for the FazyRV imem/dmem Wishbone arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fazyrv_arb_pkg;

  // Arbiter ownership states: bus free, owned by instruction fetch, owned by data port
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  // Request side of the shared Wishbone bus as driven by the arbiter
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  be;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  // Read data handed to a master whose access was abandoned by the watchdog
  localparam logic [31:0] TMO_DATA = 32'hFFFF_FFFF;

  // Width of the slave-ack watchdog counter
  localparam int TMO_CNTW = 16;

endpackage

// File: rtl/fazyrv_arb_tmo.sv
// Watchdog that counts granted cycles without a slave ack and fires at TIMEOUT.
// Latency: fire_o is combinational in the TIMEOUT-th granted cycle without ack.
// Backpressure: none; an ack in the firing cycle suppresses the fire.
module fazyrv_arb_tmo
  import fazyrv_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic busy_i,
  input  logic ack_i,
  output logic fire_o
);

  localparam logic [TMO_CNTW-1:0] LIMIT = TMO_CNTW'(TIMEOUT - 1);

  logic [TMO_CNTW-1:0] cnt_q, cnt_d;

  // Counter is zero in the first granted cycle and advances on every cycle the slave stays silent
  always_comb begin
    cnt_d = cnt_q;
    if (!busy_i) begin
      cnt_d = '0;
    end else if (!ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register; the arbiter leaves the granted state on fire, so it never wraps
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A real ack in the limit cycle wins over the watchdog
  assign fire_o = busy_i & ~ack_i & (cnt_q == LIMIT);

endmodule

// File: rtl/fazyrv_wb_arb.sv
// Two-master (imem/dmem) to one-slave Wishbone arbiter; optional ack watchdog under FAZYRV_ARB_TIMEOUT_EN.
// Latency: 1 cycle of arbitration before the slave sees cyc/stb; acks and read data pass through combinationally.
// Backpressure: the losing master is stalled by withholding its ack; one idle bus cycle separates transactions.
module fazyrv_wb_arb
  import fazyrv_arb_pkg::*;
#(
  parameter int TIMEOUT    = 255,
  parameter bit IMEM_FIRST = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_in,

  input  logic        wb_imem_stb_i,
  input  logic        wb_imem_cyc_i,
  input  logic [31:0] wb_imem_adr_i,
  output logic [31:0] wb_imem_dat_o,
  output logic        wb_imem_ack_o,

  input  logic        wb_dmem_cyc_i,
  input  logic        wb_dmem_stb_i,
  input  logic        wb_dmem_we_i,
  input  logic [3:0]  wb_dmem_be_i,
  input  logic [31:0] wb_dmem_adr_i,
  input  logic [31:0] wb_dmem_dat_i,
  output logic [31:0] wb_dmem_dat_o,
  output logic        wb_dmem_ack_o,

  output logic        wb_mem_cyc_o,
  output logic        wb_mem_stb_o,
  output logic        wb_mem_we_o,
  output logic [3:0]  wb_mem_be_o,
  output logic [31:0] wb_mem_adr_o,
  output logic [31:0] wb_mem_dat_o,
  input  logic [31:0] wb_mem_dat_i,
  input  logic        wb_mem_ack_i,

  output logic        tmo_o
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("fazyrv_wb_arb: TIMEOUT must lie in 2..65535");
  end

  arb_state_t state_q, state_d;
  // Set when imem held the most recent grant, so dmem wins the next tie
  logic       last_imem_q, last_imem_d;
  logic       req_imem, req_dmem;
  logic       tmo_fire;
  wb_req_t    bus;

  assign req_imem = wb_imem_cyc_i & wb_imem_stb_i;
  assign req_dmem = wb_dmem_cyc_i & wb_dmem_stb_i;

`ifdef FAZYRV_ARB_TIMEOUT_EN
  fazyrv_arb_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i  (clk_i),
    .rst_in (rst_in),
    .busy_i (state_q != IDLE),
    .ack_i  (wb_mem_ack_i),
    .fire_o (tmo_fire)
  );
`else
  assign tmo_fire = 1'b0;
`endif

  // Next grant: ties go to the master that did not hold the last grant; an ack, abort or timeout frees the bus
  always_comb begin
    state_d     = state_q;
    last_imem_d = last_imem_q;
    case (state_q)
      IDLE: begin
        if (req_imem && (!req_dmem || !last_imem_q)) begin
          state_d     = GNT_I;
          last_imem_d = 1'b1;
        end else if (req_dmem) begin
          state_d     = GNT_D;
          last_imem_d = 1'b0;
        end
      end
      GNT_I: begin
        if (wb_mem_ack_i || tmo_fire || !wb_imem_cyc_i) begin
          state_d = IDLE;
        end
      end
      GNT_D: begin
        if (wb_mem_ack_i || tmo_fire || !wb_dmem_cyc_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant register; reset asynchronously frees the bus and restores the tie-break preset
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      last_imem_q <= !IMEM_FIRST;
    end else begin
      state_q     <= state_d;
      last_imem_q <= last_imem_d;
    end
  end

  // Route the granted master onto the bus and the slave response back to it only
  always_comb begin
    bus           = '0;
    wb_imem_ack_o = 1'b0;
    wb_dmem_ack_o = 1'b0;
    wb_imem_dat_o = wb_mem_dat_i;
    wb_dmem_dat_o = wb_mem_dat_i;
    case (state_q)
      GNT_I: begin
        bus.cyc       = wb_imem_cyc_i;
        bus.stb       = wb_imem_cyc_i & wb_imem_stb_i;
        bus.we        = 1'b0;
        bus.be        = 4'hF;
        bus.adr       = wb_imem_adr_i;
        bus.dat       = '0;
        wb_imem_ack_o = wb_mem_ack_i | tmo_fire;
        if (tmo_fire) begin
          wb_imem_dat_o = TMO_DATA;
        end
      end
      GNT_D: begin
        bus.cyc       = wb_dmem_cyc_i;
        bus.stb       = wb_dmem_cyc_i & wb_dmem_stb_i;
        bus.we        = wb_dmem_we_i;
        bus.be        = wb_dmem_be_i;
        bus.adr       = wb_dmem_adr_i;
        bus.dat       = wb_dmem_dat_i;
        wb_dmem_ack_o = wb_mem_ack_i | tmo_fire;
        if (tmo_fire) begin
          wb_dmem_dat_o = TMO_DATA;
        end
      end
      default: begin
        bus = '0;
      end
    endcase
  end

  assign wb_mem_cyc_o = bus.cyc;
  assign wb_mem_stb_o = bus.stb;
  assign wb_mem_we_o  = bus.we;
  assign wb_mem_be_o  = bus.be;
  assign wb_mem_adr_o = bus.adr;
  assign wb_mem_dat_o = bus.dat;
  assign tmo_o        = tmo_fire;

endmodule

// File: tb/tb_fazyrv_wb_arb.sv
// Bench for fazyrv_wb_arb: directed scenarios followed by random two-master traffic.
// Latency: expectations come from a transaction-level ownership model updated each clock.
// Backpressure: masters hold requests until their expected ack; the slave acks at random.
module tb_fazyrv_wb_arb;

  localparam int TMO_LIM = 4;
`ifdef FAZYRV_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int NONE = 0;
  localparam int IM   = 1;
  localparam int DM   = 2;

  logic        clk;
  logic        rst_n;
  logic        i_stb, i_cyc;
  logic [31:0] i_adr;
  logic [31:0] wb_imem_dat_o;
  logic        wb_imem_ack_o;
  logic        d_cyc, d_stb, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_adr, d_wdat;
  logic [31:0] wb_dmem_dat_o;
  logic        wb_dmem_ack_o;
  logic        wb_mem_cyc_o, wb_mem_stb_o, wb_mem_we_o;
  logic [3:0]  wb_mem_be_o;
  logic [31:0] wb_mem_adr_o, wb_mem_dat_o;
  logic [31:0] mem_dat_i;
  logic        mem_ack_i;
  logic        tmo_o;

  int n_assert;
  int n_fail;

  // Reference model: who owns the bus, who was granted last, how long the grant has lasted
  int owner;
  bit last_imem;
  int gcyc;
  bit exp_iack_l, exp_dack_l;

  fazyrv_wb_arb #(
    .TIMEOUT    (TMO_LIM),
    .IMEM_FIRST (1'b0)
  ) dut (
    .clk_i         (clk),
    .rst_in        (rst_n),
    .wb_imem_stb_i (i_stb),
    .wb_imem_cyc_i (i_cyc),
    .wb_imem_adr_i (i_adr),
    .wb_imem_dat_o (wb_imem_dat_o),
    .wb_imem_ack_o (wb_imem_ack_o),
    .wb_dmem_cyc_i (d_cyc),
    .wb_dmem_stb_i (d_stb),
    .wb_dmem_we_i  (d_we),
    .wb_dmem_be_i  (d_be),
    .wb_dmem_adr_i (d_adr),
    .wb_dmem_dat_i (d_wdat),
    .wb_dmem_dat_o (wb_dmem_dat_o),
    .wb_dmem_ack_o (wb_dmem_ack_o),
    .wb_mem_cyc_o  (wb_mem_cyc_o),
    .wb_mem_stb_o  (wb_mem_stb_o),
    .wb_mem_we_o   (wb_mem_we_o),
    .wb_mem_be_o   (wb_mem_be_o),
    .wb_mem_adr_o  (wb_mem_adr_o),
    .wb_mem_dat_o  (wb_mem_dat_o),
    .wb_mem_dat_i  (mem_dat_i),
    .wb_mem_ack_i  (mem_ack_i),
    .tmo_o         (tmo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner     = NONE;
    gcyc      = 0;
    last_imem = 1'b1;   // IMEM_FIRST=0: dmem wins the first tie
  endtask

  // Expected outputs for the current cycle, compared against every DUT output
  task automatic model_check();
    logic        e_cyc, e_stb, e_we, e_iack, e_dack, e_tmo;
    logic [3:0]  e_be;
    logic [31:0] e_adr, e_dat, e_idat, e_ddat;
    bit          to;
    e_cyc = 0; e_stb = 0; e_we = 0; e_be = 0; e_adr = 0; e_dat = 0;
    e_iack = 0; e_dack = 0; e_tmo = 0;
    e_idat = mem_dat_i; e_ddat = mem_dat_i;
    to = TMO_EN && (owner != NONE) && (gcyc == TMO_LIM) && !mem_ack_i;
    if (owner == IM) begin
      e_cyc = i_cyc; e_stb = i_cyc & i_stb; e_be = 4'hF; e_adr = i_adr;
      e_iack = mem_ack_i | to;
      if (to) e_idat = 32'hFFFF_FFFF;
    end else if (owner == DM) begin
      e_cyc = d_cyc; e_stb = d_cyc & d_stb; e_we = d_we; e_be = d_be;
      e_adr = d_adr; e_dat = d_wdat;
      e_dack = mem_ack_i | to;
      if (to) e_ddat = 32'hFFFF_FFFF;
    end
    e_tmo = to;
    chk("m_cyc", wb_mem_cyc_o, e_cyc);
    chk("m_stb", wb_mem_stb_o, e_stb);
    chk("m_we", wb_mem_we_o, e_we);
    chk("m_be", wb_mem_be_o, e_be);
    chk("m_adr", wb_mem_adr_o, e_adr);
    chk("m_dat", wb_mem_dat_o, e_dat);
    chk("m_iack", wb_imem_ack_o, e_iack);
    chk("m_dack", wb_dmem_ack_o, e_dack);
    chk("m_idat", wb_imem_dat_o, e_idat);
    chk("m_ddat", wb_dmem_dat_o, e_ddat);
    chk("m_tmo", tmo_o, e_tmo);
    exp_iack_l = e_iack;
    exp_dack_l = e_dack;
  endtask

  // Ownership rules applied at each rising edge
  task automatic model_adv();
    bit ri, rd, done;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (owner == NONE) begin
      ri = i_cyc & i_stb;
      rd = d_cyc & d_stb;
      if (ri && rd) owner = last_imem ? DM : IM;
      else if (ri)  owner = IM;
      else if (rd)  owner = DM;
      if (owner != NONE) begin
        last_imem = (owner == IM);
        gcyc      = 1;
      end
    end else begin
      done = mem_ack_i || (TMO_EN && gcyc == TMO_LIM) ||
             (owner == IM ? !i_cyc : !d_cyc);
      if (done) owner = NONE;
      else      gcyc++;
    end
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_adv();
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic new_i();
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = $urandom;
  endtask

  task automatic new_d();
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'($urandom_range(0, 1));
    d_be = 4'($urandom); d_adr = $urandom; d_wdat = $urandom;
  endtask

  task automatic drop_i();
    i_cyc = 1'b0; i_stb = 1'b0;
  endtask

  task automatic drop_d();
    d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0;
  endtask

  task automatic rand_phase(input int n, input int pct);
    for (int k = 0; k < n; k++) begin
      if (i_cyc) begin
        if (exp_iack_l) begin
          if ($urandom_range(0, 1) == 1) new_i(); else drop_i();
        end else if ($urandom_range(0, 29) == 0) drop_i();
      end else if ($urandom_range(0, 2) == 0) new_i();
      if (d_cyc) begin
        if (exp_dack_l) begin
          if ($urandom_range(0, 1) == 1) new_d(); else drop_d();
        end else if ($urandom_range(0, 29) == 0) drop_d();
      end else if ($urandom_range(0, 2) == 0) new_d();
      mem_ack_i = ($urandom_range(0, 99) < pct);
      mem_dat_i = $urandom;
      cycle();
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    exp_iack_l = 0; exp_dack_l = 0;
    rst_n = 1'b0;
    i_cyc = 0; i_stb = 0; i_adr = 0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_be = 0; d_adr = 0; d_wdat = 0;
    mem_dat_i = 0; mem_ack_i = 0;
    model_reset();
    @(posedge clk); #1;

    // Reset holds the bus quiet even with both masters requesting and the slave acking
    i_cyc = 1; i_stb = 1; i_adr = 32'h40; d_cyc = 1; d_stb = 1; d_adr = 32'h80;
    mem_ack_i = 1;
    settle(); chk("rst_cyc", wb_mem_cyc_o, 0); chk("rst_iack", wb_imem_ack_o, 0); advance();
    cycle();
    drop_i(); drop_d(); mem_ack_i = 0;
    rst_n = 1'b1;
    cycle();

    // imem read at 0x100, slave acks on the second granted cycle
    i_cyc = 1; i_stb = 1; i_adr = 32'h100;
    settle(); chk("038_idle_stb", wb_mem_stb_o, 0); advance();
    settle(); chk("038_stb", wb_mem_stb_o, 1); chk("038_adr", wb_mem_adr_o, 32'h100); advance();
    mem_ack_i = 1; mem_dat_i = 32'h1234_5678;
    settle(); chk("038_iack", wb_imem_ack_o, 1); chk("038_idat", wb_imem_dat_o, 32'h1234_5678);
    chk("038_dack", wb_dmem_ack_o, 0); advance();
    mem_ack_i = 0; drop_i();
    cycle();

    // Simultaneous requests after reset: dmem, then imem; then alternation from last served
    pulse_reset();
    i_cyc = 1; i_stb = 1; i_adr = 32'h200;
    d_cyc = 1; d_stb = 1; d_we = 0; d_be = 4'hF; d_adr = 32'h3000_0000; d_wdat = 0;
    cycle();
    mem_ack_i = 1; mem_dat_i = 32'hA5A5_0001;
    settle(); chk("039_first_adr", wb_mem_adr_o, 32'h3000_0000);
    chk("039_first_dack", wb_dmem_ack_o, 1); chk("039_first_iack", wb_imem_ack_o, 0); advance();
    mem_ack_i = 0; drop_d();
    settle(); chk("024_gap_cyc", wb_mem_cyc_o, 0); advance();
    mem_ack_i = 1;
    settle(); chk("039_second_adr", wb_mem_adr_o, 32'h200); chk("039_second_iack", wb_imem_ack_o, 1); advance();
    mem_ack_i = 0; drop_i();
    cycle();
    d_cyc = 1; d_stb = 1;
    cycle();
    mem_ack_i = 1; cycle();
    mem_ack_i = 0; drop_d(); cycle();
    i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
    cycle();
    mem_ack_i = 1;
    settle(); chk("039_alt_adr", wb_mem_adr_o, 32'h200); chk("039_alt_iack", wb_imem_ack_o, 1); advance();
    mem_ack_i = 0; drop_i();
    settle(); chk("039_alt_gap", wb_mem_cyc_o, 0); advance();
    mem_ack_i = 1;
    settle(); chk("039_alt_dadr", wb_mem_adr_o, 32'h3000_0000); chk("039_alt_dack", wb_dmem_ack_o, 1); advance();
    mem_ack_i = 0; drop_d();
    cycle();

    // dmem write passes through unchanged while imem waits
    d_cyc = 1; d_stb = 1; d_we = 1; d_be = 4'b0011; d_adr = 32'h2000_0004; d_wdat = 32'hDEAD_BEEF;
    cycle();
    i_cyc = 1; i_stb = 1; i_adr = 32'h104;
    settle(); chk("040_we", wb_mem_we_o, 1); chk("040_be", wb_mem_be_o, 4'b0011);
    chk("040_adr", wb_mem_adr_o, 32'h2000_0004); chk("040_dat", wb_mem_dat_o, 32'hDEAD_BEEF); advance();
    settle(); chk("040_stall_iack", wb_imem_ack_o, 0); chk("040_hold_adr", wb_mem_adr_o, 32'h2000_0004); advance();
    mem_ack_i = 1;
    settle(); chk("040_dack", wb_dmem_ack_o, 1); chk("040_no_iack", wb_imem_ack_o, 0); advance();
    mem_ack_i = 0; drop_d();
    settle(); chk("040_gap", wb_mem_cyc_o, 0); advance();
    settle(); chk("040_i_adr", wb_mem_adr_o, 32'h104); chk("040_i_we", wb_mem_we_o, 0); advance();
    mem_ack_i = 1; cycle();
    mem_ack_i = 0; drop_i(); cycle();

    // Abort: master drops cyc, bus follows at once, late ack goes nowhere
    i_cyc = 1; i_stb = 1; i_adr = 32'h108;
    cycle(); cycle();
    drop_i();
    settle(); chk("041_cyc_drop", wb_mem_cyc_o, 0); chk("041_stb_drop", wb_mem_stb_o, 0); advance();
    mem_ack_i = 1; mem_dat_i = 32'h0000_0041;
    settle(); chk("041_late_iack", wb_imem_ack_o, 0); chk("041_late_dack", wb_dmem_ack_o, 0); advance();
    mem_ack_i = 0;
    cycle();

`ifdef FAZYRV_ARB_TIMEOUT_EN
    // Silent slave: watchdog completes the access on the 4th granted cycle
    i_cyc = 1; i_stb = 1; i_adr = 32'h10C;
    cycle();
    cycle(); cycle(); cycle();
    mem_dat_i = 32'h0BAD_0BAD;
    settle(); chk("042_tmo_ack", wb_imem_ack_o, 1); chk("042_tmo_dat", wb_imem_dat_o, 32'hFFFF_FFFF);
    chk("042_tmo_pulse", tmo_o, 1); advance();
    settle(); chk("042_tmo_once", tmo_o, 0); chk("042_tmo_idle", wb_mem_cyc_o, 0); advance();
    cycle(); cycle(); cycle();
    mem_ack_i = 1; mem_dat_i = 32'h55AA_55AA;
    settle(); chk("042_race_ack", wb_imem_ack_o, 1); chk("042_race_dat", wb_imem_dat_o, 32'h55AA_55AA);
    chk("042_race_tmo", tmo_o, 0); advance();
    mem_ack_i = 0; drop_i();
    cycle();
`endif

    // Asynchronous reset in the middle of a grant, then the preset tie-break again
    i_cyc = 1; i_stb = 1; i_adr = 32'h110;
    cycle();
    settle(); chk("043_pre_cyc", wb_mem_cyc_o, 1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("043_cyc", wb_mem_cyc_o, 0); chk("043_stb", wb_mem_stb_o, 0);
    chk("043_adr", wb_mem_adr_o, 0); chk("043_be", wb_mem_be_o, 0);
    chk("043_iack", wb_imem_ack_o, 0); chk("043_dack", wb_dmem_ack_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    d_cyc = 1; d_stb = 1; d_we = 0; d_be = 4'hF; d_adr = 32'h3000_0010; d_wdat = 0;
    cycle();
    settle(); chk("043_pref_adr", wb_mem_adr_o, 32'h3000_0010); advance();
    mem_ack_i = 1; cycle();
    mem_ack_i = 0; drop_d(); cycle();
    cycle();
    mem_ack_i = 1; cycle();
    mem_ack_i = 0; drop_i(); cycle();

    // Random traffic: busy slave, then a mostly silent one
    rand_phase(600, 30);
    rand_phase(300, 3);
    drop_i(); drop_d(); mem_ack_i = 0;
    cycle(); cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
